// File: rtl/struct_pattern_reg.sv
`default_nettype none
// ============================================================================
// Module   : struct_pattern_reg
// Brief    : Packed-struct register. Each accepted update builds the new value
//            field by field from input data, the current value, or a default
//            pattern. Includes a valid/ready handshake, a one-entry output
//            stage and a saturating update counter.
// Revision : 1.0 - initial release
// ============================================================================
module struct_pattern_reg #(
   parameter int                    NFIELDS = 2,
   parameter int                    FW      = 2,
   parameter int                    W       = NFIELDS * FW,
   parameter logic [NFIELDS*FW-1:0] DEFAULT = 'hD,
   parameter int                    CW      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_data,
   input  logic [NFIELDS-1:0] in_mask,
   input  logic               in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_data,
   output logic [W-1:0]       state_q,
   output logic [CW-1:0]      upd_cnt
);

   localparam logic [CW-1:0] C_CNT_MAX = '1;

   logic [W-1:0]  r_state;
   logic [W-1:0]  r_out_data;
   logic          r_out_valid;
   logic [CW-1:0] r_cnt;

   logic [W-1:0]  w_new;
   logic          w_accept;
   logic          w_drain;

   // The output slot can take a new value when empty or being drained this
   // cycle; clear and reset block acceptance outright.
   assign in_ready = !rst && !clear && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_drain  = r_out_valid && out_ready;

   // Per-field merge: masked fields from input, others from state or default.
   for (genvar i = 0; i < NFIELDS; i++) begin : g_field
      assign w_new[i*FW +: FW] = in_mask[i] ? in_data[i*FW +: FW]
                               : (in_mode ? DEFAULT[i*FW +: FW]
                                          : r_state[i*FW +: FW]);
   end

   // Struct state and update counter; clear reloads both to their idle values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DEFAULT;
         r_cnt   <= '0;
      end else if (clear) begin
         r_state <= DEFAULT;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_state <= w_new;
         if (r_cnt != C_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // One-entry output stage; a same-cycle drain and accept keeps it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= DEFAULT;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_data  <= w_new;
         r_out_valid <= 1'b1;
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end

   assign state_q   = r_state;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign upd_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_struct_pattern_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_struct_pattern_reg
// Brief    : Self-checking bench for struct_pattern_reg: vector table, hand
//            sequences for backpressure/clear/reset, and an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_struct_pattern_reg;

   localparam logic [3:0] C_DEF = 4'hD;

   logic       clk = 1'b0;
   logic       rst, clear, in_valid, in_mode, out_ready;
   logic [3:0] in_data;
   logic [1:0] in_mask;

   logic       in_ready, out_valid;
   logic [3:0] out_data, state_q;
   logic [7:0] upd_cnt;

   logic       in_ready2, out_valid2;
   logic [3:0] out_data2, state_q2;
   logic [1:0] upd_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] sb[$];

   typedef struct {
      logic [3:0] data;
      logic [1:0] mask;
      logic       mode;
      logic [3:0] exp_state;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[8];

   struct_pattern_reg #(.NFIELDS(2), .FW(2), .DEFAULT(4'hD), .CW(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
      .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .state_q(state_q), .upd_cnt(upd_cnt)
   );

   struct_pattern_reg #(.NFIELDS(2), .FW(2), .DEFAULT(4'hD), .CW(2)) dut_sat (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready2), .in_data(in_data), .in_mask(in_mask),
      .in_mode(in_mode), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .state_q(state_q2), .upd_cnt(upd_cnt2)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_new(input logic [3:0] st, input logic [3:0] d,
                                            input logic [1:0] m, input logic md);
      logic [3:0] r;
      logic [3:0] dflt;
      dflt = C_DEF;
      for (int f = 0; f < 2; f++) begin
         if (m[f])   r[f*2 +: 2] = d[f*2 +: 2];
         else if (md) r[f*2 +: 2] = dflt[f*2 +: 2];
         else        r[f*2 +: 2] = st[f*2 +: 2];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: model of the struct state, expected outputs queued on accept
   // and retired when the consumer takes them. Sampled mid-cycle.
   logic [3:0] m_state = C_DEF;
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_state = C_DEF;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_output", {28'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               chk("sb_out_data", {28'd0, out_data}, {28'd0, sb.pop_front()});
            end
         end
         if (clear) begin
            m_state = C_DEF;
         end else if (in_valid && in_ready) begin
            m_state = model_new(m_state, in_data, in_mask, in_mode);
            sb.push_back(m_state);
         end
      end
   end

   initial begin
      int sat_exp[5];
      sat_exp = '{1, 2, 3, 3, 3};

      vecs[0] = '{4'h6, 2'b01, 1'b0, 4'hE, 8'd1};
      vecs[1] = '{4'h0, 2'b10, 1'b1, 4'h1, 8'd2};
      vecs[2] = '{4'hA, 2'b00, 1'b0, 4'h1, 8'd3};
      vecs[3] = '{4'h0, 2'b00, 1'b1, 4'hD, 8'd4};
      vecs[4] = '{4'h5, 2'b11, 1'b0, 4'h5, 8'd5};
      vecs[5] = '{4'h0, 2'b11, 1'b1, 4'h0, 8'd6};
      vecs[6] = '{4'hB, 2'b10, 1'b1, 4'h9, 8'd7};
      vecs[7] = '{4'h7, 2'b01, 1'b0, 4'hB, 8'd8};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
      out_ready = 1'b1; in_data = 4'h0; in_mask = 2'b00;

      // Reset state
      tick(); tick();
      chk("rst_state_q",   {28'd0, state_q},  32'hD);
      chk("rst_out_data",  {28'd0, out_data}, 32'hD);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_upd_cnt",   {24'd0, upd_cnt},  32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Saturating counter on the CW=2 instance
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = 4'(k + 1); in_mask = 2'b11; in_mode = 1'b0;
         tick();
         chk("sat_upd_cnt",   {30'd0, upd_cnt2},  32'(sat_exp[k]));
         chk("sat_out_valid", {31'd0, out_valid2}, 32'd1);
         chk("wide_upd_cnt",  {24'd0, upd_cnt},   32'(k + 1));
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Vector table, consumer always ready
      for (int v = 0; v < 8; v++) begin
         in_valid = 1'b1; in_data = vecs[v].data; in_mask = vecs[v].mask;
         in_mode = vecs[v].mode; out_ready = 1'b1;
         tick();
         chk("vec_state_q",   {28'd0, state_q},   {28'd0, vecs[v].exp_state});
         chk("vec_out_data",  {28'd0, out_data},  {28'd0, vecs[v].exp_state});
         chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
         chk("vec_upd_cnt",   {24'd0, upd_cnt},   {24'd0, vecs[v].exp_cnt});
         chk("vec_model",     {28'd0, state_q},   {28'd0, m_state});
      end

      // Backpressure: held output blocks new updates
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'hF; in_mask = 2'b11; in_mode = 1'b0;
      #1;
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_out_data",  {28'd0, out_data},  32'hB);
         chk("bp_hold_state_q",   {28'd0, state_q},   32'hB);
         chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      tick();
      chk("bp_out_data",  {28'd0, out_data},  32'hF);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_upd_cnt",   {24'd0, upd_cnt},   32'd9);

      // Clear versus a concurrent update request
      out_ready = 1'b0; clear = 1'b1; in_valid = 1'b1; in_data = 4'h0; in_mask = 2'b11;
      #1;
      chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("clr_state_q",   {28'd0, state_q},   32'hD);
      chk("clr_upd_cnt",   {24'd0, upd_cnt},   32'd0);
      chk("clr_out_data",  {28'd0, out_data},  32'hF);
      chk("clr_out_valid", {31'd0, out_valid}, 32'd1);
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_out_data",  {28'd0, out_data},  32'hF);

      // Reset drops a pending output
      in_valid = 1'b1; in_data = 4'h3; in_mask = 2'b11;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pend_out_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_out_data",  {28'd0, out_data},  32'hD);
      chk("rst_mid_state_q",   {28'd0, state_q},   32'hD);
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/struct_pattern_reg.md
# struct_pattern_reg

Parametrised packed-struct register that builds each new value from a mix of per-field input data, the current value and a compile-time default pattern. It generalises the fixed constant-pattern struct assignment into a run-time, clocked block with a valid/ready handshake and a one-entry output stage. It sits between a field-update producer and any consumer that needs the assembled struct word and an update count.

## Interface
- NFIELDS, 2, number of struct fields (>=1)
- FW, 2, width of each field in bits (>=1)
- W, NFIELDS*FW, total struct width (derived; not overridden)
- DEFAULT, 4'hD, W-bit default pattern; field i = DEFAULT[i*FW +: FW]
- CW, 8, width of the update counter

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous reload of state to DEFAULT, counter to 0
- in_valid  in  1  update request valid
- in_ready  out  1  update accepted when in_valid && in_ready
- in_data  in  W  field values, field i at [i*FW +: FW]
- in_mask  in  NFIELDS  bit i=1: field i taken from in_data
- in_mode  in  1  0: unmasked fields keep current value; 1: unmasked fields take DEFAULT
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  W  last accepted struct value
- state_q  out  W  current struct value
- upd_cnt  out  CW  saturating count of accepted updates

## Operation
- Clock is clk; reset is synchronous, active-high, on rst.
- Reset values: state_q=DEFAULT, out_data=DEFAULT, out_valid=0, upd_cnt=0; in_ready=1 the cycle after reset deasserts.
- in_ready = !rst && !clear && (!out_valid || out_ready). Combinational; does not depend on in_valid.
- On accept, per field i: new[i] = in_mask[i] ? in_data[i] : (in_mode ? DEFAULT[i] : state_q[i]).
- On accept: state_q<=new, out_data<=new, out_valid<=1, upd_cnt<=upd_cnt+1 unless all ones (saturate).
- Output drain: out_valid && out_ready && no accept -> out_valid<=0; out_data holds its value.
- Drain and accept in the same cycle: out_valid stays 1, out_data takes the new value.
- clear: state_q<=DEFAULT, upd_cnt<=0. No accept occurs because in_ready=0. out_valid and out_data are unaffected, and a pending output still drains normally.
- rst takes priority over clear and over any handshake. Reset mid-transfer drops the pending output.
- in_mask all zeros with in_mode=1 is a legal "restore default" update and is counted.
- in_mask all ones ignores in_mode.

## Timing
- Latency: accept at edge N -> out_data/out_valid/state_q visible after edge N.
- Throughput: one update per cycle while out_ready=1.
- Back-to-back accepts use state_q as updated by the previous accept. There is no forwarding hazard.
- out_valid and out_data are stable while out_valid && !out_ready.
- Paths: only in_ready is combinational, from out_valid, out_ready, clear and rst.

## Test plan
- Reset: hold rst 2 cycles -> state_q=4'hD, out_data=4'hD, out_valid=0, upd_cnt=0, then in_ready=1.
- Keep-merge: in_data=4'h6, in_mask=2'b01, in_mode=0 from state D -> next cycle state_q=out_data=4'hE, out_valid=1, upd_cnt=1.
- Default-merge: from state E, in_data=4'h0, in_mask=2'b10, in_mode=1 -> state_q=4'h1, upd_cnt=2.
- Backpressure: out_valid=1, out_ready=0, in_valid=1 with data 4'hF, mask 2'b11 -> in_ready=0; out_data and state_q are held for 3 cycles. Raise out_ready -> accepted that cycle, out_data=4'hF next cycle, out_valid stays 1.
- Clear vs update: clear=1 with in_valid=1 (data 4'h0, mask 2'b11) -> in_ready=0, state_q=4'hD, upd_cnt=0; out_data keeps its prior value until drained.
- Saturation: CW=2, 5 consecutive accepts with out_ready=1 -> upd_cnt goes 1,2,3,3,3; out_valid stays 1 throughout.
